// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

    localparam int UART_BYTE_W = 8;
    localparam int LEN_W       = 3;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_DONE,
        GAP
    } sched_state_t;

    // Packets longer than the latch can hold are truncated, not rejected.
    function automatic logic [LEN_W-1:0] clamp_len(
        input logic [LEN_W-1:0] len,
        input int               max_bytes
    );
        if (int'(len) > max_bytes) begin
            return LEN_W'(max_bytes);
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int off = 1; off <= N; off++) begin
            j = (int'(ptr) + off) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin packet scheduler in front of a single UART byte transmitter.
// Grants one requester, latches its packet and feeds bytes through the tx handshake.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int MAX_BYTES  = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NREQ-1:0]                      req,
    input  logic [NREQ*LEN_W-1:0]                req_len,
    input  logic [NREQ*UART_BYTE_W*MAX_BYTES-1:0] req_data,
    output logic [NREQ-1:0]                      grant,
    output logic [NREQ-1:0]                      req_done,
    output logic                                 tx_start,
    output logic [UART_BYTE_W-1:0]               tx_byte,
    input  logic                                 tx_busy,
    input  logic                                 tx_done,
    output logic                                 busy,
    output logic [15:0]                          pkt_count
);

    localparam int IW = $clog2(NREQ);
    localparam int PW = UART_BYTE_W * MAX_BYTES;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam sched_state_t POST = (GAP_CYCLES > 0) ? GAP : IDLE;

    sched_state_t   state;
    logic [IW-1:0]  ptr;
    logic [PW-1:0]  shift;
    logic [LEN_W-1:0] cnt;
    logic [GW-1:0]  gap_cnt;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;
    logic [PW-1:0]   sel_data;
    logic [LEN_W-1:0] sel_len;
    logic            pkt_end;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_comb begin
        sel_data = '0;
        sel_len  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_idx == IW'(i)) begin
                sel_data = req_data[i*PW +: PW];
                sel_len  = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // A zero-length packet finishes straight out of SEND.
    assign pkt_end = ((state == SEND) && (cnt == '0)) ||
                     ((state == WAIT_DONE) && tx_done &&
                      (cnt == LEN_W'(1)));

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= IW'(NREQ - 1);
            shift     <= '0;
            cnt       <= '0;
            gap_cnt   <= '0;
            grant     <= '0;
            req_done  <= '0;
            tx_start  <= 1'b0;
            tx_byte   <= '0;
            pkt_count <= '0;
        end else begin
            tx_start <= 1'b0;
            req_done <= '0;
            unique case (state)
                IDLE: begin
                    if (arb_any) begin
                        grant <= arb_gnt;
                        ptr   <= arb_idx;
                        shift <= sel_data;
                        cnt   <= clamp_len(sel_len, MAX_BYTES);
                        state <= SEND;
                    end
                end
                SEND: begin
                    if ((cnt != '0) && !tx_busy) begin
                        tx_start <= 1'b1;
                        tx_byte  <= shift[UART_BYTE_W-1:0];
                        state    <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        shift <= shift >> UART_BYTE_W;
                        cnt   <= cnt - LEN_W'(1);
                        state <= SEND;
                    end
                end
                GAP: begin
                    if (int'(gap_cnt) >= GAP_CYCLES - 1) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
            if (pkt_end) begin
                req_done  <= grant;
                grant     <= '0;
                pkt_count <= pkt_count + 16'd1;
                gap_cnt   <= '0;
                state     <= POST;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched against a packet-level scheduling model.
module tb_uart_tx_sched;

    localparam int NREQ = 2;
    localparam int MAXB = 4;
    localparam int GAP  = 16;

    typedef logic [7:0] bq_t[$];

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [5:0]  req_len;
    logic [63:0] req_data;
    logic [1:0]  grant;
    logic [1:0]  req_done;
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic        tx_busy;
    logic        tx_done;
    logic        busy;
    logic [15:0] pkt_count;

    int compared   = 0;
    int mismatched = 0;

    int cyc      = 0;
    int tx_delay = 20;
    int n_start  = 0;
    int viol     = 0;
    logic busy_s = 1'b0;
    logic [1:0] prev_grant = '0;
    logic [7:0] sent_q[$];
    logic [1:0] done_q[$];
    int done_cyc[$];
    int grant_cyc[$];

    // Model state: last granted requester and packet total.
    int m_last  = NREQ - 1;
    int m_count = 0;

    uart_tx_sched #(
        .NREQ       (NREQ),
        .MAX_BYTES  (MAXB),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_len   (req_len),
        .req_data  (req_data),
        .grant     (grant),
        .req_done  (req_done),
        .tx_start  (tx_start),
        .tx_byte   (tx_byte),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            busy_s = tx_busy;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                sent_q.push_back(tx_byte);
                n_start++;
                if (busy_s) viol++;
            end
            if (req_done !== 2'b00) begin
                done_q.push_back(req_done);
                done_cyc.push_back(cyc);
                if (req_done !== prev_grant) viol++;
            end
            if (grant !== 2'b00 && prev_grant === 2'b00) grant_cyc.push_back(cyc);
            prev_grant = grant;
        end
    end

    // Transmitter: tx_done arrives tx_delay cycles after each accepted start.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1 && !rst) begin
                repeat (tx_delay) @(negedge clk);
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    function automatic bq_t exp_bytes(input logic [31:0] data, input logic [2:0] len);
        bq_t q;
        int  eff;
        eff = (int'(len) > MAXB) ? MAXB : int'(len);
        for (int k = 0; k < eff; k++) q.push_back(data[8*k +: 8]);
        return q;
    endfunction

    function automatic int m_pick(input logic [1:0] mask);
        for (int o = 1; o <= NREQ; o++) begin
            if (mask[(m_last + o) % NREQ]) return (m_last + o) % NREQ;
        end
        return 0;
    endfunction

    task automatic wait_grant(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (grant !== 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req_done !== 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_one(input logic [1:0] mask, output bit ok,
                           output logic [1:0] g, output logic [1:0] d);
        bit okg, okd, oki;
        req = mask;
        wait_grant(100, okg);
        g   = grant;
        req = '0;
        wait_done(5000, okd);
        d = req_done;
        wait_idle(200, oki);
        ok = okg & okd & oki;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        req_len = '0;
        req_data = '0;
        tx_busy = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if (grant !== 2'b00) begin mismatched++; $display("FAIL reset_grant: got %b want 00", grant); end
        compared++;
        if (req_done !== 2'b00) begin mismatched++; $display("FAIL reset_req_done: got %b want 00", req_done); end
        compared++;
        if (tx_start !== 1'b0) begin mismatched++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        compared++;
        if (tx_byte !== 8'h00) begin mismatched++; $display("FAIL reset_tx_byte: got %h want 00", tx_byte); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
        compared++;
        if (pkt_count !== 16'h0000) begin mismatched++; $display("FAIL reset_pkt_count: got %h want 0000", pkt_count); end
        rst = 1'b0;
        m_last = NREQ - 1;
        m_count = 0;
        @(negedge clk);
    endtask

    task automatic test_single();
        bq_t exp;
        int s0, st0, d0, w;
        bit ok;
        req_len[2:0] = 3'd3;
        req_data[31:0] = 32'h0033_2211;
        tx_delay = 20;
        exp = exp_bytes(req_data[31:0], 3'd3);
        s0 = sent_q.size();
        st0 = n_start;
        d0 = done_q.size();
        w = m_pick(2'b01);
        m_last = w;
        req = 2'b01;
        @(negedge clk);
        compared++;
        if (grant !== 2'(1 << w)) begin mismatched++; $display("FAIL single_grant_latency: got %b want %b", grant, 2'(1 << w)); end
        req = '0;
        @(negedge clk);
        compared++;
        if (tx_start !== 1'b1 || tx_byte !== exp[0]) begin
            mismatched++;
            $display("FAIL single_first_start: got start=%b byte=%h want start=1 byte=%h", tx_start, tx_byte, exp[0]);
        end
        wait_done(500, ok);
        compared++;
        if (!ok || req_done !== 2'b01) begin mismatched++; $display("FAIL single_req_done: got ok=%0d done=%b want done=01", ok, req_done); end
        m_count++;
        wait_idle(100, ok);
        compared++;
        if (n_start - st0 !== exp.size()) begin mismatched++; $display("FAIL single_start_count: got %0d want %0d", n_start - st0, exp.size()); end
        for (int k = 0; k < exp.size(); k++) begin
            compared++;
            if (sent_q[s0 + k] !== exp[k]) begin mismatched++; $display("FAIL single_byte%0d: got %h want %h", k, sent_q[s0 + k], exp[k]); end
        end
        compared++;
        if (done_q.size() - d0 !== 1) begin mismatched++; $display("FAIL single_done_once: got %0d want 1", done_q.size() - d0); end
        compared++;
        if (pkt_count !== 16'(m_count)) begin mismatched++; $display("FAIL single_pkt_count: got %0d want %0d", pkt_count, m_count); end
    endtask

    task automatic test_contention();
        bq_t e0, e1;
        int s0, g0, dc0, w;
        bit ok;
        logic [7:0] want;
        req_len = {3'd1, 3'd1};
        req_data = {32'h0000_00B1, 32'h0000_00A0};
        tx_delay = 20;
        e0 = exp_bytes(req_data[31:0], 3'd1);
        e1 = exp_bytes(req_data[63:32], 3'd1);
        s0 = sent_q.size();
        g0 = grant_cyc.size();
        dc0 = done_cyc.size();
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_done(1000, ok);
            compared++;
            if (!ok) begin mismatched++; $display("FAIL contention_done%0d: got timeout want req_done", k); end
            if (k == 3) req = '0;
        end
        wait_idle(100, ok);
        for (int k = 0; k < 4; k++) begin
            w = m_pick(2'b11);
            m_last = w;
            m_count++;
            want = (w == 1) ? e1[0] : e0[0];
            compared++;
            if (sent_q[s0 + k] !== want) begin mismatched++; $display("FAIL contention_byte%0d: got %h want %h", k, sent_q[s0 + k], want); end
        end
        for (int k = 0; k < 3; k++) begin
            compared++;
            if (grant_cyc[g0 + k + 1] - done_cyc[dc0 + k] !== GAP + 1) begin
                mismatched++;
                $display("FAIL contention_gap%0d: got %0d want %0d", k, grant_cyc[g0 + k + 1] - done_cyc[dc0 + k], GAP + 1);
            end
        end
        compared++;
        if (pkt_count !== 16'(m_count)) begin mismatched++; $display("FAIL contention_pkt_count: got %0d want %0d", pkt_count, m_count); end
    endtask

    task automatic test_backpressure();
        bq_t exp;
        int s0, st0, w;
        bit ok;
        req_len[5:3] = 3'd2;
        req_data[63:32] = $urandom;
        exp = exp_bytes(req_data[63:32], 3'd2);
        tx_delay = 3;
        tx_busy = 1'b1;
        s0 = sent_q.size();
        w = m_pick(2'b10);
        m_last = w;
        req = 2'b10;
        wait_grant(100, ok);
        compared++;
        if (!ok || grant !== 2'(1 << w)) begin mismatched++; $display("FAIL bp_grant: got %b want %b", grant, 2'(1 << w)); end
        req = '0;
        st0 = n_start;
        repeat (50) @(negedge clk);
        #1;
        compared++;
        if (n_start !== st0) begin mismatched++; $display("FAIL bp_no_start: got %0d starts want 0", n_start - st0); end
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("FAIL bp_busy: got %b want 1", busy); end
        tx_busy = 1'b0;
        @(negedge clk);
        compared++;
        if (tx_start !== 1'b1 || tx_byte !== exp[0]) begin
            mismatched++;
            $display("FAIL bp_release_start: got start=%b byte=%h want start=1 byte=%h", tx_start, tx_byte, exp[0]);
        end
        wait_done(500, ok);
        m_count++;
        wait_idle(100, ok);
        for (int k = 0; k < exp.size(); k++) begin
            compared++;
            if (sent_q[s0 + k] !== exp[k]) begin mismatched++; $display("FAIL bp_byte%0d: got %h want %h", k, sent_q[s0 + k], exp[k]); end
        end
        compared++;
        if (pkt_count !== 16'(m_count)) begin mismatched++; $display("FAIL bp_pkt_count: got %0d want %0d", pkt_count, m_count); end
    endtask

    task automatic test_boundaries();
        bq_t exp;
        int s0, st0, w;
        bit ok;
        logic [1:0] g, d;
        tx_delay = 4;
        req_len[2:0] = 3'd0;
        req_data[31:0] = $urandom;
        st0 = n_start;
        w = m_pick(2'b01);
        m_last = w;
        req = 2'b01;
        wait_grant(100, ok);
        req = '0;
        @(negedge clk);
        compared++;
        if (req_done !== 2'(1 << w) || grant !== 2'b00) begin
            mismatched++;
            $display("FAIL len0_done: got done=%b grant=%b want done=%b grant=00", req_done, grant, 2'(1 << w));
        end
        m_count++;
        wait_idle(100, ok);
        compared++;
        if (n_start !== st0) begin mismatched++; $display("FAIL len0_no_start: got %0d starts want 0", n_start - st0); end
        compared++;
        if (pkt_count !== 16'(m_count)) begin mismatched++; $display("FAIL len0_pkt_count: got %0d want %0d", pkt_count, m_count); end

        req_len[5:3] = 3'd7;
        req_data[63:32] = $urandom;
        exp = exp_bytes(req_data[63:32], 3'd7);
        s0 = sent_q.size();
        st0 = n_start;
        w = m_pick(2'b10);
        m_last = w;
        run_one(2'b10, ok, g, d);
        m_count++;
        compared++;
        if (!ok || n_start - st0 !== MAXB) begin mismatched++; $display("FAIL len7_clamp: got %0d bytes want %0d", n_start - st0, MAXB); end
        for (int k = 0; k < exp.size(); k++) begin
            compared++;
            if (sent_q[s0 + k] !== exp[k]) begin mismatched++; $display("FAIL len7_byte%0d: got %h want %h", k, sent_q[s0 + k], exp[k]); end
        end
    endtask

    task automatic test_random();
        bq_t exp;
        int s0, st0, w;
        bit ok;
        logic [1:0] mask, g, d;
        for (int r = 0; r < 8; r++) begin
            mask = 2'($urandom_range(1, 3));
            req_len = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
            req_data = {$urandom, $urandom};
            tx_delay = $urandom_range(1, 6);
            w = m_pick(mask);
            exp = (w == 1) ? exp_bytes(req_data[63:32], req_len[5:3]) : exp_bytes(req_data[31:0], req_len[2:0]);
            m_last = w;
            s0 = sent_q.size();
            st0 = n_start;
            run_one(mask, ok, g, d);
            m_count++;
            compared++;
            if (!ok || g !== 2'(1 << w) || d !== 2'(1 << w)) begin
                mismatched++;
                $display("FAIL rand%0d_grant: got ok=%0d grant=%b done=%b want %b", r, ok, g, d, 2'(1 << w));
            end
            compared++;
            if (n_start - st0 !== exp.size()) begin mismatched++; $display("FAIL rand%0d_count: got %0d want %0d", r, n_start - st0, exp.size()); end
            for (int k = 0; k < exp.size(); k++) begin
                compared++;
                if (sent_q[s0 + k] !== exp[k]) begin mismatched++; $display("FAIL rand%0d_byte%0d: got %h want %h", r, k, sent_q[s0 + k], exp[k]); end
            end
            compared++;
            if (pkt_count !== 16'(m_count)) begin mismatched++; $display("FAIL rand%0d_pkt_count: got %0d want %0d", r, pkt_count, m_count); end
        end
    endtask

    task automatic test_reset_mid();
        bq_t exp;
        int s0, st0, d0, w;
        bit ok;
        logic [1:0] g, d;
        req_len = {3'd2, 3'd4};
        req_data = {$urandom, $urandom};
        exp = exp_bytes(req_data[31:0], 3'd4);
        tx_delay = 20;
        st0 = n_start;
        m_last = m_pick(2'b01);
        req = 2'b01;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #1;
            if (n_start >= st0 + 2) begin
                ok = 1'b1;
                break;
            end
        end
        compared++;
        if (!ok) begin mismatched++; $display("FAIL rmid_reach_byte2: got timeout want second start"); end
        d0 = done_q.size();
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        req = '0;
        #1;
        compared++;
        if (grant !== 2'b00 || req_done !== 2'b00) begin mismatched++; $display("FAIL rmid_async_grant: got grant=%b done=%b want 00/00", grant, req_done); end
        compared++;
        if (tx_start !== 1'b0 || tx_byte !== 8'h00) begin mismatched++; $display("FAIL rmid_async_tx: got start=%b byte=%h want 0/00", tx_start, tx_byte); end
        compared++;
        if (busy !== 1'b0 || pkt_count !== 16'h0000) begin mismatched++; $display("FAIL rmid_async_busy: got busy=%b cnt=%h want 0/0000", busy, pkt_count); end
        m_last = NREQ - 1;
        m_count = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        compared++;
        if (done_q.size() !== d0) begin mismatched++; $display("FAIL rmid_no_done: got %0d done pulses want 0", done_q.size() - d0); end
        s0 = sent_q.size();
        w = m_pick(2'b11);
        m_last = w;
        run_one(2'b11, ok, g, d);
        m_count++;
        compared++;
        if (!ok || g !== 2'(1 << w)) begin mismatched++; $display("FAIL rmid_first_grant: got %b want %b", g, 2'(1 << w)); end
        for (int k = 0; k < exp.size(); k++) begin
            compared++;
            if (sent_q[s0 + k] !== exp[k]) begin mismatched++; $display("FAIL rmid_byte%0d: got %h want %h", k, sent_q[s0 + k], exp[k]); end
        end
        compared++;
        if (pkt_count !== 16'(m_count)) begin mismatched++; $display("FAIL rmid_pkt_count: got %0d want %0d", pkt_count, m_count); end
    endtask

    task automatic test_wrap();
        bit ok;
        int w;
        logic [1:0] g, d;
        req_len = {3'd1, 3'd1};
        req_data = {$urandom, $urandom};
        tx_delay = 2;
        force dut.pkt_count = 16'hFFFF;
        @(negedge clk);
        release dut.pkt_count;
        m_count = 16'hFFFF;
        w = m_pick(2'b10);
        m_last = w;
        run_one(2'b10, ok, g, d);
        m_count = (m_count + 1) & 16'hFFFF;
        compared++;
        if (!ok || pkt_count !== 16'(m_count)) begin mismatched++; $display("FAIL wrap_pkt_count: got %h want %h", pkt_count, 16'(m_count)); end
    endtask

    task automatic test_protocol();
        compared++;
        if (viol !== 0) begin mismatched++; $display("FAIL protocol: got %0d violations want 0", viol); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_boundaries();
        test_random();
        test_reset_mid();
        test_wrap();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one UART byte transmitter between NREQ packet requesters.
- Each requester offers a packet of 1..MAX_BYTES bytes.
- The scheduler grants one requester, latches its packet, and sequences the bytes one at a time into the transmitter's start/busy/done handshake.
- Between packets it enforces an inter-packet gap.
- It sits between the button/register front-end logic and the UART transmitter in the board-level top.

Parameters:
NREQ, 2, number of requesters (2..4)
MAX_BYTES, 4, maximum bytes per packet
GAP_CYCLES, 16, idle clk cycles after each packet before the next arbitration (0 = no gap)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req  in  NREQ  per-requester packet request level
req_len  in  NREQ*3  per-requester byte count; slice i = bits [3i+2:3i]
req_data  in  NREQ*8*MAX_BYTES  per-requester packet; byte 0 = bits [7:0] of the slice, sent first
grant  out  NREQ  one-hot, high from latch until req_done
req_done  out  NREQ  one-cycle pulse to the granted requester when its packet is complete
tx_start  out  1  one-cycle pulse requesting the transmitter to send tx_byte
tx_byte  out  8  byte to transmit; valid in the tx_start cycle
tx_busy  in  1  transmitter is busy; tx_start is never issued while high
tx_done  in  1  one-cycle pulse from the transmitter at the end of a frame
busy  out  1  high in every state except IDLE
pkt_count  out  16  packets completed since reset; wraps at 0xFFFF->0

Behaviour:
- Reset (async, rst=1): state=IDLE; grant=0, req_done=0, tx_start=0, tx_byte=0x00, busy=0, pkt_count=0; RR pointer = NREQ-1, so req[0] has highest priority first.
- States: IDLE, SEND, WAIT_DONE, GAP.
- IDLE:
  - If any req bit is high, pick the first set bit searching from (ptr+1) mod NREQ upward.
  - Next edge: grant=onehot(i), ptr=i; latch req_data slice into shift register and eff_len into byte counter; go SEND.
- eff_len = min(req_len, MAX_BYTES).
- eff_len==0: skip SEND. req_done[i] pulses on the cycle after grant; grant drops with it. Go to GAP. pkt_count still increments.
- SEND:
  - If tx_busy==0: tx_start=1 for one cycle, tx_byte=shift[7:0]; go WAIT_DONE.
  - Else hold in SEND with no pulse.
- WAIT_DONE:
  - tx_start=0. On tx_done: shift register >>8, counter-1.
  - If the counter reaches 0: req_done[i]=1 for one cycle, grant cleared the same cycle, pkt_count+1; go GAP, or IDLE if GAP_CYCLES==0.
  - Otherwise go SEND.
  - A tx_done outside WAIT_DONE is ignored.
- GAP: counts GAP_CYCLES clk cycles, then IDLE. req is ignored here.
- Latency: req high at edge k in IDLE -> grant at k+1 -> earliest tx_start at k+2.
- Requester rules:
  - req_len/req_data need only be stable in the IDLE cycle where the grant is taken; the data is latched.
  - req deasserted after grant does not abort the packet; it completes normally.
  - req still high after req_done means a new packet. It competes under round-robin, so the other requester wins if it is also requesting.
- Simultaneous requests: strict round-robin, so no requester is granted twice in a row while another is waiting.
- rst mid-packet: immediate return to reset values. A partially sent packet is abandoned, with no req_done.
- Transmitter contract: tx_start and tx_done are in the clk domain. The transmitter raises tx_busy or pulses tx_done no earlier than the cycle after tx_start.

Decomposition:
- Shared package uart_pkg holds:
  - typedef enum sched_state_t {IDLE, SEND, WAIT_DONE, GAP}
  - constant UART_BYTE_W = 8
  - packet length width constant LEN_W = 3
- One natural sub-module: rr_arbiter (req vector + pointer -> one-hot grant + index), purely combinational. It is reused for future multi-source muxing.

Test Plan:
- Single packet: req[0]=1, len=3, data=0x00_33_22_11, transmitter model with done 20 cycles after start -> tx_byte sequence 0x11, 0x22, 0x33; exactly 3 tx_start; req_done[0] once; pkt_count=1.
- Contention: req=2'b11 held, len=1 each, data0=0xA0, data1=0xB1 -> bytes 0xA0, 0xB1, 0xA0, 0xB1 (alternating); GAP_CYCLES=16 cycles of busy between each req_done and the next grant.
- Backpressure: tx_busy held high 50 cycles after grant -> no tx_start until tx_busy falls; first tx_start the cycle after tx_busy=0.
- Boundaries: len=0 -> req_done after 1 cycle, zero tx_start; len=7 -> clamped, exactly 4 bytes sent.
- Reset mid-packet: rst pulsed during WAIT_DONE of byte 2 of 4 -> all outputs at reset values asynchronously, no req_done. After release, req[0] is granted first and its packet is resent from byte 0.
- Counter wrap: force pkt_count to 0xFFFF, complete one packet -> pkt_count=0x0000.
